// File: rtl/card_read_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : card_read_seq                                              |
// | Description : Card-reader column sequencer. Accepts one card as a stream |
// |               of 12-bit hole patterns, presents each latched column to   |
// |               the card-code-to-EBCDIC translator and emits the resulting |
// |               bytes on a valid/ready byte interface. EBCDIC mode emits   |
// |               one translated byte per column and records the first       |
// |               invalid punch; column-binary mode emits two raw 6-bit      |
// |               bytes per column.                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clk          sole clock, rising edge                                 |
// |   i_reset        synchronous active-high reset                           |
// |   i_start        begin a card (honoured only when idle)                  |
// |   i_mode         0 = EBCDIC, 1 = column binary; sampled with i_start     |
// |   i_abort        drop the current card at the next edge, no o_done       |
// |   i_col_valid    reader column available                                 |
// |   i_col_holes    hole pattern, bit 11 = row 12 ... bit 0 = row 9         |
// |   o_col_ready    column accepted when o_col_ready & i_col_valid          |
// |   o_xlat_holes   latched column, drives the translator                   |
// |   i_xlat_ebcdic  translator byte for o_xlat_holes (combinational)        |
// |   i_xlat_bad     translator invalid-punch flag (combinational)           |
// |   o_byte_valid   byte available to the channel                           |
// |   o_byte         output byte                                             |
// |   i_byte_ready   byte taken when o_byte_valid & i_byte_ready             |
// |   o_busy         high in every state except idle                         |
// |   o_done         one-cycle pulse after the last byte of a card           |
// |   o_col_count    columns fully emitted on this card                      |
// |   o_bad          sticky invalid-punch flag (EBCDIC mode only)            |
// |   o_err_col      index of the first invalid column                       |
// +--------------------------------------------------------------------------+

module card_read_seq #(
   parameter int COLS = 80
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_mode,
   input  logic        i_abort,
   input  logic        i_col_valid,
   input  logic [11:0] i_col_holes,
   output logic        o_col_ready,
   output logic [11:0] o_xlat_holes,
   input  logic [7:0]  i_xlat_ebcdic,
   input  logic        i_xlat_bad,
   output logic        o_byte_valid,
   output logic [7:0]  o_byte,
   input  logic        i_byte_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic [6:0]  o_col_count,
   output logic        o_bad,
   output logic [6:0]  o_err_col
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_COL = 3'd1,
      S_EMIT0    = 3'd2,
      S_EMIT1    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam logic [6:0] C_COLS = 7'(COLS);

   state_t      r_state;
   state_t      w_next_state;
   logic [11:0] r_holes;
   logic        r_mode;
   logic [6:0]  r_col_count;
   logic        r_bad;
   logic [6:0]  r_err_col;

   logic [6:0]  w_count_inc;
   logic        w_col_done;   // last byte of the current column handed off
   logic        w_set_bad;    // first invalid column of this card handed off
   logic        w_start;
   logic        w_col_load;

   assign w_start     = (r_state == S_IDLE) && i_start;
   assign w_col_load  = (r_state == S_WAIT_COL) && i_col_valid;
   assign w_count_inc = r_col_count + 7'd1;

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      o_col_ready  = 1'b0;
      o_byte_valid = 1'b0;
      o_byte       = 8'h00;
      o_busy       = 1'b1;
      o_done       = 1'b0;
      w_col_done   = 1'b0;
      w_set_bad    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               w_next_state = S_WAIT_COL;
            end
         end

         S_WAIT_COL: begin
            o_col_ready = 1'b1;
            if (i_col_valid) begin
               w_next_state = S_EMIT0;
            end
         end

         S_EMIT0: begin
            o_byte_valid = 1'b1;
            // Column binary sends zone rows first; EBCDIC takes the
            // translator output, which follows the hole register directly.
            o_byte = r_mode ? {2'b00, r_holes[11:6]} : i_xlat_ebcdic;
            if (i_byte_ready) begin
               if (r_mode) begin
                  w_next_state = S_EMIT1;
               end else begin
                  w_col_done = 1'b1;
                  w_set_bad  = i_xlat_bad & ~r_bad;
               end
            end
         end

         S_EMIT1: begin
            o_byte_valid = 1'b1;
            o_byte       = {2'b00, r_holes[5:0]};
            if (i_byte_ready) begin
               w_col_done = 1'b1;
            end
         end

         S_DONE: begin
            o_done       = 1'b1;
            w_next_state = S_IDLE;
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      if (w_col_done) begin
         w_next_state = (w_count_inc == C_COLS) ? S_DONE : S_WAIT_COL;
      end

      // Abort overrides every transition, but a byte handshake in the
      // same cycle still counts (the counters above already saw it).
      if (i_abort && (r_state != S_IDLE)) begin
         w_next_state = S_IDLE;
      end
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_holes     <= 12'h000;
         r_mode      <= 1'b0;
         r_col_count <= 7'd0;
         r_bad       <= 1'b0;
         r_err_col   <= 7'd0;
      end else begin
         r_state <= w_next_state;

         if (w_start) begin
            r_mode      <= i_mode;
            r_col_count <= 7'd0;
            r_bad       <= 1'b0;
            r_err_col   <= 7'd0;
         end

         // Hole register is only written on a column handshake, so it
         // keeps the last column after the card finishes.
         if (w_col_load) begin
            r_holes <= i_col_holes;
         end

         if (w_col_done) begin
            r_col_count <= w_count_inc;
         end

         // Error column is the count before this column's increment.
         if (w_set_bad) begin
            r_bad     <= 1'b1;
            r_err_col <= r_col_count;
         end
      end
   end

   assign o_xlat_holes = r_holes;
   assign o_col_count  = r_col_count;
   assign o_bad        = r_bad;
   assign o_err_col    = r_err_col;

endmodule

`default_nettype wire

// File: tb/tb_card_read_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_card_read_seq                                           |
// | Description : Self-checking bench for card_read_seq. Columns are queued  |
// |               per card; each accepted column pushes its expected bytes   |
// |               into a scoreboard that a separate monitor drains on every  |
// |               byte handshake. Card-level results (count, bad, first bad  |
// |               column, latency) are derived from the whole card up front. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_card_read_seq;

   localparam int COLS = 80;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_mode;
   logic        i_abort;
   logic        i_col_valid;
   logic [11:0] i_col_holes;
   logic        o_col_ready;
   logic [11:0] o_xlat_holes;
   logic [7:0]  i_xlat_ebcdic;
   logic        i_xlat_bad;
   logic        o_byte_valid;
   logic [7:0]  o_byte;
   logic        i_byte_ready;
   logic        o_busy;
   logic        o_done;
   logic [6:0]  o_col_count;
   logic        o_bad;
   logic [6:0]  o_err_col;

   card_read_seq #(.COLS(COLS)) u_dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_mode        (i_mode),
      .i_abort       (i_abort),
      .i_col_valid   (i_col_valid),
      .i_col_holes   (i_col_holes),
      .o_col_ready   (o_col_ready),
      .o_xlat_holes  (o_xlat_holes),
      .i_xlat_ebcdic (i_xlat_ebcdic),
      .i_xlat_bad    (i_xlat_bad),
      .o_byte_valid  (o_byte_valid),
      .o_byte        (o_byte),
      .i_byte_ready  (i_byte_ready),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_col_count   (o_col_count),
      .o_bad         (o_bad),
      .o_err_col     (o_err_col)
   );

   always #5 i_clk = ~i_clk;

   // Translator stand-in: blank column gives 0x40; more than one digit
   // punch among rows 1..7 is an invalid punch.
   function automatic logic [7:0] xlat_byte(input logic [11:0] h);
      return h[7:0] ^ {h[11:8], h[11:8]} ^ 8'h40;
   endfunction

   function automatic logic xlat_is_bad(input logic [11:0] h);
      return ($countones(h[8:2]) > 1);
   endfunction

   assign i_xlat_ebcdic = xlat_byte(o_xlat_holes);
   assign i_xlat_bad    = xlat_is_bad(o_xlat_holes);

   function automatic logic [11:0] gen_hole(input bit bad);
      logic [11:0] h;
      int a;
      int b;
      h      = 12'($urandom);
      h[8:2] = 7'd0;
      a      = $urandom_range(6);
      if (bad) begin
         b = (a + 1 + $urandom_range(5)) % 7;
         h[2 + a] = 1'b1;
         h[2 + b] = 1'b1;
      end else if ($urandom_range(1) == 1) begin
         h[2 + a] = 1'b1;
      end
      return h;
   endfunction

   // Scoreboard
   typedef struct {
      logic [7:0] b;
      int         col;
      logic       bad;
      logic       last;
   } exp_t;

   typedef struct {
      int   count;
      logic bad;
      int   err;
      int   lat;
   } card_t;

   exp_t        exp_q[$];
   card_t       done_q[$];
   logic [11:0] col_q[$];
   logic [11:0] card [COLS];

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   cyc_start = 0;
   int   done_seen = 0;
   int   bytes_seen = 0;
   int   feed_idx = 0;
   logic cur_mode = 1'b0;
   logic m_bad = 1'b0;
   int   m_err = 0;
   bit   feed_en = 1'b0;
   bit   col_rand = 1'b0;
   bit   rdy_rand = 1'b0;
   int   stall_col = -1;
   int   stall_left = 0;
   int   stall_seen = 0;
   bit   start_with_abort = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Column feeder
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         i_col_valid = feed_en && (col_q.size() > 0) &&
                       (!col_rand || ($urandom_range(3) != 0));
         i_col_holes = (col_q.size() > 0) ? col_q[0] : 12'($urandom);
      end
   end

   // Byte-ready driver, with an optional stall on one column index
   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (stall_left > 0 && o_byte_valid && (int'(o_col_count) == stall_col)) begin
            i_byte_ready = 1'b0;
            stall_left--;
            stall_seen++;
         end else begin
            i_byte_ready = rdy_rand ? ($urandom_range(2) != 0) : 1'b1;
         end
      end
   end

   // Monitor
   initial begin
      logic       p_valid;
      logic       p_ready;
      logic       p_abort;
      logic       p_reset;
      logic [7:0] p_byte;
      logic       bad_pend;
      exp_t       e;
      card_t      c;
      logic [11:0] h;
      p_valid  = 1'b0;
      p_ready  = 1'b0;
      p_abort  = 1'b0;
      p_reset  = 1'b1;
      p_byte   = 8'h00;
      bad_pend = 1'b0;
      forever begin
         @(negedge i_clk);
         if (bad_pend && !p_reset) begin
            chk("o_bad_after_byte", o_bad, m_bad);
            if (m_bad) chk("o_err_col_after_byte", o_err_col, m_err);
         end
         bad_pend = 1'b0;
         if (!i_reset) begin
            chk("ready_valid_exclusive", o_col_ready & o_byte_valid, 1'b0);
            if (p_valid && !p_ready && !p_abort && !p_reset) begin
               chk("byte_valid_held", o_byte_valid, 1'b1);
               chk("byte_stable", o_byte, p_byte);
            end
            if (o_byte_valid && i_byte_ready) begin
               bytes_seen++;
               if (exp_q.size() == 0) begin
                  fail_msg("unexpected_byte");
               end else begin
                  e = exp_q.pop_front();
                  chk("byte_value", o_byte, e.b);
                  if (e.last) begin
                     if (!cur_mode && e.bad && !m_bad) begin
                        m_bad = 1'b1;
                        m_err = e.col;
                     end
                     bad_pend = 1'b1;
                  end
               end
            end
            if (o_col_ready && i_col_valid) begin
               if (col_q.size() == 0) begin
                  fail_msg("unexpected_column_accept");
               end else begin
                  h = col_q.pop_front();
                  if (cur_mode) begin
                     exp_q.push_back('{b: {2'b00, h[11:6]}, col: feed_idx, bad: 1'b0, last: 1'b0});
                     exp_q.push_back('{b: {2'b00, h[5:0]},  col: feed_idx, bad: 1'b0, last: 1'b1});
                  end else begin
                     exp_q.push_back('{b: xlat_byte(h), col: feed_idx, bad: xlat_is_bad(h), last: 1'b1});
                  end
                  feed_idx++;
               end
            end
            if (o_done) begin
               done_seen++;
               if (done_q.size() == 0) begin
                  fail_msg("unexpected_done");
               end else begin
                  c = done_q.pop_front();
                  chk("done_col_count", o_col_count, c.count);
                  chk("done_bad", o_bad, c.bad);
                  if (c.bad) chk("done_err_col", o_err_col, c.err);
                  if (c.lat >= 0) chk("done_latency", cyc - cyc_start, c.lat);
                  chk("bytes_left_at_done", exp_q.size(), 0);
               end
            end
            if (i_start && !o_busy) cyc_start = cyc;
         end
         p_valid = o_byte_valid;
         p_ready = i_byte_ready;
         p_abort = i_abort;
         p_reset = i_reset;
         p_byte  = o_byte;
      end
   end

   // Queue a card from card[], derive its card-level result, pulse start.
   task automatic start_card(input logic mode, input bit check_lat);
      card_t c;
      c.count = COLS;
      c.bad   = 1'b0;
      c.err   = 0;
      for (int i = 0; i < COLS; i++) begin
         col_q.push_back(card[i]);
         if (!mode && !c.bad && xlat_is_bad(card[i])) begin
            c.bad = 1'b1;
            c.err = i;
         end
      end
      // Latency in edges from the start edge to the cycle showing o_done:
      // the o_done cycle is cycle 2*COLS+2 (or 3*COLS+2) counting the
      // i_start cycle as cycle 1.
      c.lat = check_lat ? (mode ? 3 * COLS + 1 : 2 * COLS + 1) : -1;
      done_q.push_back(c);
      cur_mode   = mode;
      feed_idx   = 0;
      m_bad      = 1'b0;
      m_err      = 0;
      bytes_seen = 0;
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_mode  = mode;
      i_abort = start_with_abort;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_mode  = 1'($urandom);
   endtask

   task automatic wait_done(input string name);
      int n0;
      int t;
      n0 = done_seen;
      t  = 0;
      while (done_seen == n0 && t < 2000) begin
         @(negedge i_clk);
         t++;
      end
      if (done_seen == n0) begin
         fail_msg({name, "_done_timeout"});
         flush();
      end
   endtask

   function automatic void flush();
      col_q.delete();
      exp_q.delete();
      done_q.delete();
   endfunction

   task automatic fill_random(input int bad_pct);
      for (int i = 0; i < COLS; i++) card[i] = gen_hole($urandom_range(99) < bad_pct);
   endtask

   initial begin
      int d0;
      bit hit;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_mode  = 1'b0;
      i_abort = 1'b0;
      i_col_valid  = 1'b0;
      i_col_holes  = 12'h000;
      i_byte_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("rst_col_ready", o_col_ready, 1'b0);
      chk("rst_byte_valid", o_byte_valid, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_col_count", o_col_count, 7'd0);
      chk("rst_bad", o_bad, 1'b0);
      chk("rst_err_col", o_err_col, 7'd0);
      chk("rst_xlat_holes", o_xlat_holes, 12'h000);
      feed_en = 1'b1;

      // Blank EBCDIC card, no stalls
      for (int i = 0; i < COLS; i++) card[i] = 12'h000;
      start_card(1'b0, 1'b1);
      wait_done("blank_ebcdic");
      chk("blank_bytes", bytes_seen, COLS);

      // Column binary, constant 0xA5C -> 0x29, 0x1C
      for (int i = 0; i < COLS; i++) card[i] = 12'hA5C;
      start_card(1'b1, 1'b1);
      wait_done("colbin");
      chk("colbin_bytes", bytes_seen, 2 * COLS);
      @(negedge i_clk);
      chk("holes_kept_idle", o_xlat_holes, 12'hA5C);

      // Backpressure: five-cycle stall on column 3
      fill_random(0);
      stall_col  = 3;
      stall_left = 5;
      stall_seen = 0;
      start_card(1'b0, 1'b0);
      wait_done("backpressure");
      chk("stall_cycles", stall_seen, 5);
      chk("backpressure_bytes", bytes_seen, COLS);
      stall_col = -1;

      // Invalid punches on columns 7 and 12, mode 0 then mode 1
      col_rand = 1'b1;
      rdy_rand = 1'b1;
      for (int i = 0; i < COLS; i++) card[i] = gen_hole(i == 7 || i == 12);
      start_card(1'b0, 1'b0);
      wait_done("bad_mode0");
      @(negedge i_clk);
      chk("bad_mode0_flag", o_bad, 1'b1);
      chk("bad_mode0_err_col", o_err_col, 7'd7);
      start_card(1'b1, 1'b0);
      wait_done("bad_mode1");
      @(negedge i_clk);
      chk("bad_mode1_flag", o_bad, 1'b0);

      // i_start while busy is ignored
      fill_random(10);
      start_card(1'b1, 1'b0);
      repeat (15) @(posedge i_clk);
      #1;
      i_start = 1'b1;
      i_mode  = 1'b0;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      wait_done("start_while_busy");
      chk("start_while_busy_bytes", bytes_seen, 2 * COLS);

      // Abort in EMIT0 of column 40 with ready low
      rdy_rand   = 1'b0;
      fill_random(0);
      stall_col  = 40;
      stall_left = 1000;
      start_card(1'b0, 1'b0);
      hit = 1'b0;
      for (int t = 0; t < 2000 && !hit; t++) begin
         @(posedge i_clk);
         #2;
         if (o_byte_valid && o_col_count == 7'd40) hit = 1'b1;
      end
      if (!hit) fail_msg("abort_point_timeout");
      i_abort = 1'b1;
      @(posedge i_clk);
      #1;
      i_abort    = 1'b0;
      stall_left = 0;
      stall_col  = -1;
      d0 = done_seen;
      @(negedge i_clk);
      chk("abort_busy", o_busy, 1'b0);
      chk("abort_byte_valid", o_byte_valid, 1'b0);
      chk("abort_col_count", o_col_count, 7'd40);
      repeat (4) @(negedge i_clk);
      chk("abort_no_done", done_seen, d0);
      flush();

      // Restart with start and abort together: start wins
      fill_random(10);
      start_with_abort = 1'b1;
      start_card(1'b0, 1'b0);
      start_with_abort = 1'b0;
      @(negedge i_clk);
      chk("restart_busy", o_busy, 1'b1);
      chk("restart_col_count", o_col_count, 7'd0);
      chk("restart_bad", o_bad, 1'b0);
      wait_done("restart");

      // Reset in the middle of a card
      for (int i = 0; i < COLS; i++) card[i] = gen_hole(i == 2 || i == 5);
      col_rand = 1'b0;
      start_card(1'b0, 1'b0);
      repeat (30) @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      @(negedge i_clk);
      chk("bad_before_reset", o_bad, 1'b1);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      flush();
      @(negedge i_clk);
      chk("midrst_col_ready", o_col_ready, 1'b0);
      chk("midrst_byte_valid", o_byte_valid, 1'b0);
      chk("midrst_busy", o_busy, 1'b0);
      chk("midrst_done", o_done, 1'b0);
      chk("midrst_col_count", o_col_count, 7'd0);
      chk("midrst_bad", o_bad, 1'b0);
      chk("midrst_err_col", o_err_col, 7'd0);
      chk("midrst_xlat_holes", o_xlat_holes, 12'h000);

      // Random cards
      col_rand = 1'b1;
      rdy_rand = 1'b1;
      for (int k = 0; k < 3; k++) begin
         fill_random(15);
         start_card(1'($urandom), 1'b0);
         wait_done("random_card");
      end

      repeat (3) @(negedge i_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/card_read_seq.md
# card_read_seq

Column sequencer for the card-reader path of the 2821 control unit. It accepts one 80-column card as a stream of 12-bit hole patterns and presents each latched column to the card-code-to-EBCDIC translator. It emits the resulting bytes to the channel-side byte interface using a valid/ready handshake. In EBCDIC mode it also records invalid-punch errors; in column-binary mode it emits two raw 6-bit bytes per column.

## Interface
- COLS, 80: columns per card; 7-bit column counters; COLS must be 1..127.

- i_clk  in  1  sole clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; begins a card; ignored unless IDLE.
- i_mode  in  1  sampled with i_start; 0 = EBCDIC, 1 = column binary.
- i_abort  in  1  ends the current card at the next edge; no o_done.
- i_col_valid  in  1  reader column available.
- i_col_holes  in  12  hole pattern; bit 11 = row 12 (top), bit 10 = row 11, bit 9 = row 0, bits 8..0 = rows 1..9.
- o_col_ready  out  1  column accepted when o_col_ready & i_col_valid.
- o_xlat_holes  out  12  latched column, driven to the translator.
- i_xlat_ebcdic  in  8  translator result for o_xlat_holes; combinational.
- i_xlat_bad  in  1  translator invalid-punch flag; combinational.
- o_byte_valid  out  1  byte available to the channel.
- o_byte  out  8  output byte.
- i_byte_ready  in  1  byte taken when o_byte_valid & i_byte_ready.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse after the last byte of a card is accepted.
- o_col_count  out  7  columns fully emitted on this card.
- o_bad  out  1  sticky; set if any EBCDIC-mode column is invalid.
- o_err_col  out  7  index of the first invalid column; valid only while o_bad = 1.

## Operation
- States: IDLE, WAIT_COL, EMIT0, EMIT1, DONE.
- IDLE:
  - On i_start: latch i_mode, clear o_col_count, o_bad and o_err_col, then go to WAIT_COL.
- WAIT_COL:
  - o_col_ready = 1.
  - On a column handshake: load the hole register from i_col_holes, then go to EMIT0.
- EMIT0:
  - o_byte_valid = 1.
  - o_byte = i_xlat_ebcdic when mode = 0.
  - o_byte = {2'b00, holes[11:6]} when mode = 1.
  - On byte accept, mode 1: go to EMIT1.
  - On byte accept, mode 0: the column is complete.
  - On byte accept in mode 0, if i_xlat_bad = 1 and o_bad = 0: set o_bad and load o_err_col with o_col_count.
  - Later bad columns do not change o_err_col.
- EMIT1:
  - o_byte_valid = 1; o_byte = {2'b00, holes[5:0]}.
  - On byte accept: the column is complete.
- Column complete:
  - Increment o_col_count.
  - If the new count equals COLS, go to DONE; otherwise go to WAIT_COL.
- DONE:
  - o_done = 1 for exactly this cycle; next state is IDLE.
- i_xlat_bad is ignored in mode 1.
- i_abort:
  - In any non-IDLE state: go to IDLE at the next edge.
  - Any byte offered in that cycle counts as accepted only if i_byte_ready is high in the same cycle.
  - o_col_count, o_bad and o_err_col keep their values.
  - If i_abort and i_start are both high in IDLE, the start wins.
- i_start while busy is ignored.
- The hole register holds its value in IDLE after a card, so o_xlat_holes keeps the last column.

## Timing
- Reset values: state IDLE, hole register 0, mode 0, o_col_count 0, o_bad 0, o_err_col 0.
- Reset values of all handshake and status strobes: o_col_ready, o_byte_valid, o_busy and o_done all 0.
- Reset takes priority over i_start and i_abort.
- Column accepted at edge N → o_byte_valid high from cycle N+1.
- o_byte is a registered-input combinational path: holes are registered, and the translator lies between the register and o_byte.
- o_byte is stable while o_byte_valid & ~i_byte_ready.
- o_byte_valid never drops without a handshake, except on i_abort or i_reset.
- o_col_ready and o_byte_valid are never high in the same cycle.
- Peak throughput with i_col_valid and i_byte_ready held high:
  - Mode 0: 2 cycles per column.
  - Mode 1: 3 cycles per column.
- A full card completes in 2·COLS + 2 cycles from i_start in mode 0.
- o_done asserts the cycle after the final byte handshake.
- o_bad and o_err_col update on the same edge as the offending byte handshake.

## Test plan
- EBCDIC card, no stalls: i_start with mode 0, 80 columns of holes 0x000 (blank) and a translator model returning 0x40 → 80 bytes of 0x40. Expect o_done at cycle 162 after i_start, o_col_count = 80, o_bad = 0.
- Column binary: mode 1, column holes 0xA5C → bytes 0x29 then 0x1C. Expect 160 bytes per card and o_done after the 160th accept.
- Backpressure: hold i_byte_ready low for 5 cycles on column 3 → o_byte constant and o_col_ready low throughout. Expect no column lost, and still 80 bytes in order.
- Invalid punch: i_xlat_bad forced on columns 7 and 12 in mode 0 → o_bad set at the column-7 byte accept, o_err_col = 7 thereafter. Repeat in mode 1 → o_bad stays 0.
- Abort: i_abort while in EMIT0 at column 40, with i_byte_ready low → IDLE next cycle, no o_done, o_col_count = 40. A following i_start restarts cleanly with count 0.
- Reset and start rules: i_reset in the middle of a card → all outputs return to their reset values next cycle. i_start while busy has no effect.
